// File: rtl/spu_add_scheduler.sv
// rtl/spu_add_scheduler.sv - round-robin scheduler sharing one SPU adder among requesters
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   en                    issue enable (in-flight work always completes)
//   req_valid/req_ready   per-requester handshake, req_ready is a one-hot grant
//   req_a/req_b           4-bit operands, requester i at [4i+3:4i]
//   req_c/req_d           3-bit operands, requester i at [3i+2:3i]
//   add_a..add_d          registered operands to the external adder
//   add_sum               adder result, valid ADD_LATENCY edges after add_* change
//   res_valid/res_ready   result FIFO handshake (first-word-fall-through)
//   res_sum/res_id        head sum and the requester it belongs to
//   busy                  work in flight or results waiting
module spu_add_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 1,
  parameter int RES_DEPTH   = 4,
  parameter int ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]   req_c,
  input  logic [3*NUM_REQ-1:0]   req_d,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic [2:0]             add_c,
  output logic [2:0]             add_d,
  input  logic [7:0]             add_sum,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_sum,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  localparam int CNT_W  = $clog2(RES_DEPTH + 1);
  localparam int PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int STAGES = ADD_LATENCY + 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight_count;
  logic [CNT_W:0]   credit_used;
  logic             can_issue;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;

  logic             tag_v  [STAGES];
  logic [ID_W-1:0]  tag_id [STAGES];

  logic [7:0]       mem_sum [RES_DEPTH];
  logic [ID_W-1:0]  mem_id  [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_push;
  logic             fifo_pop;

  // Every issued op reserves a FIFO slot until it is popped, so a capture
  // can never find the FIFO full. Counts are registered, so a pop only
  // returns its credit on the following cycle.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign can_issue   = en && (credit_used < (CNT_W+1)'(RES_DEPTH));

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (can_issue && !grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_id       = ID_W'(idx);
        req_ready[idx] = 1'b1;
      end
    end
  end

  // The tag leaving the last stage lines up with add_sum for that op.
  assign fifo_push = tag_v[STAGES-1];
  assign fifo_pop  = res_valid && res_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      add_a          <= '0;
      add_b          <= '0;
      add_c          <= '0;
      add_d          <= '0;
      inflight_count <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
      for (int e = 0; e < RES_DEPTH; e++) begin
        mem_sum[e] <= '0;
        mem_id[e]  <= '0;
      end
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        add_a  <= req_a[int'(grant_id)*4 +: 4];
        add_b  <= req_b[int'(grant_id)*4 +: 4];
        add_c  <= req_c[int'(grant_id)*3 +: 3];
        add_d  <= req_d[int'(grant_id)*3 +: 3];
      end

      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int s = 1; s < STAGES; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end

      if (grant_any && !fifo_push)
        inflight_count <= inflight_count + CNT_W'(1);
      else if (!grant_any && fifo_push)
        inflight_count <= inflight_count - CNT_W'(1);

      if (fifo_push) begin
        mem_sum[wr_ptr] <= add_sum;
        mem_id[wr_ptr]  <= tag_id[STAGES-1];
        wr_ptr <= (wr_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (fifo_pop)
        rd_ptr <= (rd_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

      if (fifo_push && !fifo_pop)
        fifo_count <= fifo_count + CNT_W'(1);
      else if (!fifo_push && fifo_pop)
        fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  assign res_valid = (fifo_count != '0);
  assign res_sum   = mem_sum[rd_ptr];
  assign res_id    = mem_id[rd_ptr];
  assign busy      = (inflight_count != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_spu_add_scheduler.sv
// tb/tb_spu_add_scheduler.sv - scoreboard bench for spu_add_scheduler
module tb_spu_add_scheduler;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [4*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_c, req_d;
  logic [3:0]   add_a, add_b;
  logic [2:0]   add_c, add_d;
  logic [7:0]   add_sum;
  logic         res_valid;
  logic         res_ready;
  logic [7:0]   res_sum;
  logic [1:0]   res_id;
  logic         busy;

  spu_add_scheduler #(.NUM_REQ(N), .ADD_LATENCY(1), .RES_DEPTH(D), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
    .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // One-edge external adder
  always @(posedge clk)
    add_sum <= 8'(add_a) + 8'(add_b) + 8'(add_c) + 8'(add_d);

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
  } exp_t;

  exp_t sb[$];
  exp_t pop_log[$];
  int   total = 0;
  int   bad = 0;
  int   outstanding = 0;
  int   mptr = 0;
  int   grant_count = 0;
  int   grant_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the reference model sees the inputs that will be sampled at
  // the next rising edge and decides what must happen there.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    int g, s;
    exp_t e;
    exp_rdy = '0;
    g = -1;
    s = 0;
    if (reset) begin
      sb.delete();
      outstanding = 0;
      mptr = 0;
    end else begin
      check("busy", 32'(busy), 32'(outstanding != 0));
      if (en && outstanding < D)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
        s = int'(req_a[4*g +: 4]) + int'(req_b[4*g +: 4]) + int'(req_c[3*g +: 3]) + int'(req_d[3*g +: 3]);
        e.id  = g[1:0];
        e.sum = s[7:0];
        sb.push_back(e);
        grant_log.push_back(g);
        mptr = (g + 1) % N;
        outstanding++;
        grant_count++;
      end
      if (res_valid && res_ready) begin
        e.id  = res_id;
        e.sum = res_sum;
        pop_log.push_back(e);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_unexpected: got id=%0d sum=%0d with nothing outstanding at %0t", res_id, res_sum, $time);
        end else begin
          e = sb.pop_front();
          check("res_sum", 32'(res_sum), 32'(e.sum));
          check("res_id", 32'(res_id), 32'(e.id));
        end
        outstanding--;
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] c, input logic [2:0] d);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_c[3*i +: 3] = c;
    req_d[3*i +: 3] = d;
  endtask

  task automatic rand_ops();
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    req_c = 12'($urandom);
    req_d = 12'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(0));
    check({name, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, pl0, s1, s3;
    reset = 1'b1;
    en = 1'b1;
    req_valid = '0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_add_a", 32'(add_a), 32'(0));
    check("rst_res_sum", 32'(res_sum), 32'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Single request from requester 2
    @(posedge clk); #1;
    set_req(2, 4'd3, 4'd5, 3'd1, 3'd2);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); check("t1_valid_e0", 32'(res_valid), 32'(0));
    @(negedge clk); check("t1_valid_e1", 32'(res_valid), 32'(0));
    @(negedge clk);
    check("t1_valid_e2", 32'(res_valid), 32'(1));
    check("t1_sum", 32'(res_sum), 32'(11));
    check("t1_id", 32'(res_id), 32'(2));
    @(negedge clk); check("t1_busy_after_pop", 32'(busy), 32'(0));

    // Full round-robin burst
    @(posedge clk); #1;
    grant_log.delete();
    g0 = grant_count;
    req_valid = 4'b1111;
    rand_ops();
    repeat (15) begin
      @(posedge clk); #1 rand_ops();
    end
    @(posedge clk); #1 req_valid = '0;
    check("t2_grants", 32'(grant_count - g0), 32'(16));
    check("t2_first", 32'(grant_log[0]), 32'(3));
    for (int i = 1; i < 8; i++)
      check("t2_order", 32'(grant_log[i]), 32'((3 + i) % 4));
    wait_idle("t2_drain");

    // Backpressure: credits exhaust at RES_DEPTH
    @(posedge clk); #1;
    res_ready = 1'b0;
    rand_ops();
    req_valid = 4'b0011;
    g0 = grant_count;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t3_grants", 32'(grant_count - g0), 32'(4));
    check("t3_blocked", 32'(req_ready), 32'(0));
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    g0 = grant_count;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t3_one_more", 32'(grant_count - g0), 32'(1));
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b1;
    wait_idle("t3_drain");

    // Boundary operands
    pl0 = pop_log.size();
    @(posedge clk); #1;
    set_req(1, 4'd15, 4'd15, 3'd7, 3'd7);
    set_req(3, 4'd0, 4'd0, 3'd0, 3'd0);
    req_valid = 4'b1010;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    wait_idle("t4_drain");
    s1 = -1;
    s3 = -1;
    for (int i = pl0; i < pop_log.size(); i++) begin
      if (pop_log[i].id == 2'd1) s1 = int'(pop_log[i].sum);
      if (pop_log[i].id == 2'd3) s3 = int'(pop_log[i].sum);
    end
    check("t4_max_sum", 32'(s1), 32'(44));
    check("t4_zero_sum", 32'(s3), 32'(0));

    // Reset with one op in flight and two results queued
    @(posedge clk); #1;
    res_ready = 1'b0;
    rand_ops();
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("t5_pre_outstanding", 32'(outstanding), 32'(3));
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("t5_rst_res_valid", 32'(res_valid), 32'(0));
    check("t5_rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    res_ready = 1'b1;
    pl0 = pop_log.size();
    rand_ops();
    req_valid = 4'b1001;
    @(negedge clk);
    check("t5_ptr_restart", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1 req_valid = '0;
    wait_idle("t5_drain");
    check("t5_only_new", 32'(pop_log.size() - pl0), 32'(1));

    // Enable gating
    @(posedge clk); #1;
    en = 1'b0;
    rand_ops();
    req_valid = 4'b1111;
    repeat (5) begin
      @(negedge clk);
      check("t6_en_low", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1 en = 1'b1;
    g0 = grant_count;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    check("t6_burst", 32'(grant_count - g0), 32'(3));
    g0 = grant_count;
    repeat (6) @(negedge clk);
    check("t6_no_more", 32'(grant_count - g0), 32'(0));
    req_valid = '0;
    wait_idle("t6_drain");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      rand_ops();
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b1;
    en = 1'b1;
    wait_idle("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spu_add_scheduler.md
Name: spu_add_scheduler

Overview:
- Round-robin scheduler that shares the single SPU addition datapath (A,B 4-bit; C,D 3-bit; 8-bit sum) among NUM_REQ requesters.
- Accepts operand sets over per-requester valid/ready, issues at most one per cycle to the adder, and tracks in-flight operations with an ID tag pipeline.
- Returns each sum tagged with its requester ID through a credit-protected result FIFO, so results are never dropped under backpressure.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADD_LATENCY, 1: clock edges from add_* change to a valid add_sum, 1..4.
- RES_DEPTH, 4: result FIFO entries; must be >= ADD_LATENCY+1.
- ID_W, 2: requester ID width; equals clog2(NUM_REQ).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  issue enable; 0 blocks new grants, in-flight work completes
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid&ready
- req_a  in  4*NUM_REQ  A operands, requester i at [4i+3:4i]
- req_b  in  4*NUM_REQ  B operands, same packing
- req_c  in  3*NUM_REQ  C operands, requester i at [3i+2:3i]
- req_d  in  3*NUM_REQ  D operands, same packing
- add_a/add_b  out  4  registered operands to adder
- add_c/add_d  out  3  registered operands to adder
- add_sum  in  8  adder result
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accept
- res_sum  out  8  head sum
- res_id  out  ID_W  head requester ID
- busy  out  1  high when inflight_count != 0 or the FIFO is non-empty

Behaviour:
- Reset values:
  - All outputs 0; add_* = 0.
  - RR pointer = 0, FIFO empty, tag pipeline cleared, counters 0.
- Reset is asynchronous at any time: in-flight operations and FIFO contents are discarded, and no result for them ever appears.
- Credit rule:
  - can_issue = en && (fifo_count + inflight_count < RES_DEPTH), using registered counts.
  - A same-cycle FIFO pop does not free a credit until the next cycle.
- Arbitration:
  - If can_issue, req_ready is one-hot on the first requester with req_valid set, searching ptr, ptr+1, ... modulo NUM_REQ.
  - Otherwise req_ready = 0.
  - req_ready is combinational from req_valid, ptr and counts; it never asserts for a requester whose valid is low.
- Pointer update: on a handshake with requester g, ptr <= (g+1) mod NUM_REQ. ptr is unchanged when no grant occurs.
- Issue:
  - On the handshake edge E, add_a..add_d <= the granted requester's operands.
  - A tag {valid, id} enters a shift pipeline of ADD_LATENCY+1 stages.
  - add_* hold their last value when nothing is issued.
- Capture:
  - When the tag exits the pipeline, at edge E+ADD_LATENCY+1, {add_sum, id} is written to the FIFO.
  - inflight_count decrements on that edge; fifo_count increments.
  - The credit rule guarantees the FIFO is never full at a write.
- Throughput and latency:
  - One issue per cycle sustained while credits allow.
  - With an empty FIFO, res_valid rises in the cycle after edge E+ADD_LATENCY+1.
  - Results leave in issue order.
- Result FIFO:
  - First-word-fall-through; res_sum and res_id reflect the head entry.
  - Pop on res_valid&&res_ready.
  - A write and a pop on the same edge keep fifo_count unchanged; pointers wrap modulo RES_DEPTH.
- Arithmetic: the adder is external. The scheduler passes add_sum unmodified, 8 bits, with no saturation.
- en deassert mid-stream: grants stop the next cycle, tags already in the pipeline still complete, and busy falls once the FIFO drains.

Test Plan:
- Defaults. Reset, then requester 2 sends A=3,B=5,C=1,D=2 with a model adder (sum=A+B+C+D, 1 edge) → grant on req_ready[2]; res_valid 2 edges later; res_sum=11, res_id=2; busy falls after the pop.
- All four requesters valid continuously, distinct operands, res_ready=1 → grant order 0,1,2,3,0,...; one grant per cycle; results in that order with correct sums.
- res_ready=0, requesters 0 and 1 always valid → exactly RES_DEPTH=4 grants, then req_ready=0. Raise res_ready for one cycle → one more grant the following cycle. No result lost or duplicated.
- Boundary operands A=15,B=15,C=7,D=7 → res_sum=44. A=B=C=D=0 → res_sum=0, with res_id correct for each.
- Assert reset with 1 in flight and 2 entries in the FIFO → res_valid=0 and busy=0 immediately. After reset release, a new request yields only its own result, and ptr restarts at 0.
- en=0 with all requesters valid → req_ready stays 0. Drop en during a burst → the in-flight result still delivered, no further grants.
